// File: rtl/mic_frame_aligner.sv
// Gathers one sample from each of mics A/B/C and emits them as an aligned triplet.
// Drops sets that overrun or time out. Define ALIGN_DROP_CNT_EN to get the drop_count port.
module mic_frame_aligner #(
    parameter int unsigned TIMEOUT_CYCLES = 512,
    parameter int unsigned DROP_CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic        b_valid,
    input  logic        c_valid,
    input  logic [15:0] a_data,
    input  logic [15:0] b_data,
    input  logic [15:0] c_data,
    output logic        out_valid,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_c,
    output logic        overrun,
    output logic        timeout
`ifdef ALIGN_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t        state, state_n;
    logic [2:0]    flags, flags_n;
    logic [2:0]    valids;
    logic [TW-1:0] timer, timer_n;
    logic [15:0]   ha, hb, hc;
    logic          ovr, tmo, cmp;
    logic          out_valid_n;
    logic [15:0]   out_a_n, out_b_n, out_c_n;

    assign valids = {c_valid, b_valid, a_valid};

    always_comb begin
        ovr         = |(valids & flags);
        tmo         = !ovr && (state == FILL) && (timer == TW'(TIMEOUT_CYCLES - 1));
        cmp         = !ovr && !tmo && (&(flags | valids));
        state_n     = state;
        flags_n     = flags;
        timer_n     = (state == FILL) ? timer + TW'(1) : '0;
        out_valid_n = 1'b0;
        out_a_n     = out_a;
        out_b_n     = out_b;
        out_c_n     = out_c;
        if (ovr || tmo) begin
            // Discarded set restarts from whatever arrived on this edge.
            flags_n = valids;
            state_n = (|valids) ? FILL : IDLE;
            timer_n = '0;
        end else if (cmp) begin
            out_valid_n = 1'b1;
            out_a_n     = a_valid ? a_data : ha;
            out_b_n     = b_valid ? b_data : hb;
            out_c_n     = c_valid ? c_data : hc;
            flags_n     = '0;
            state_n     = IDLE;
            timer_n     = '0;
        end else if (|valids) begin
            flags_n = flags | valids;
            state_n = FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flags     <= '0;
            timer     <= '0;
            ha        <= '0;
            hb        <= '0;
            hc        <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            flags     <= flags_n;
            timer     <= timer_n;
            if (a_valid) ha <= a_data;
            if (b_valid) hb <= b_data;
            if (c_valid) hc <= c_data;
            out_valid <= out_valid_n;
            out_a     <= out_a_n;
            out_b     <= out_b_n;
            out_c     <= out_c_n;
            overrun   <= ovr;
            timeout   <= tmo;
        end
    end

`ifdef ALIGN_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if ((ovr || tmo) && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_CNT_W'(1);
        end
    end
`endif

endmodule
